// File: rtl/difftest_runahead_commit_queue.sv
// Multi-channel commit-event queue for run-ahead difftest.
// Accepts a whole cycle of events or none, tagging each with a sequence index.
module difftest_runahead_commit_queue #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int PC_W   = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                   io_clock,
  input  logic                   io_reset,
  input  logic [7:0]             io_coreid,
  input  logic                   io_flush,
  input  logic [NUM_CH-1:0]      io_in_valid,
  input  logic [NUM_CH*PC_W-1:0] io_in_pc,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [7:0]             io_out_coreid,
  output logic [7:0]             io_out_index,
  output logic [PC_W-1:0]        io_out_pc,
  output logic [CW-1:0]          io_count,
  output logic                   io_overflow,
  output logic [15:0]            io_drop_cnt
);

  logic [PC_W-1:0] pc_mem  [DEPTH];
  logic [7:0]      idx_mem [DEPTH];
  logic [7:0]      cid_mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    seq_q, seq_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic              deq;
  logic              accept;
  logic              drop;
  logic [CW-1:0]     n;
  logic [CW-1:0]     n_acc;
  logic [CW-1:0]     free;
  logic [CW-1:0]     off;
  logic [16:0]       dsum;
  logic [NUM_CH-1:0] wr_en;
  logic [AW-1:0]     wr_addr [NUM_CH];
  logic [7:0]        wr_idx  [NUM_CH];

  assign io_out_valid  = count_q != '0;
  assign io_out_pc     = pc_mem[head_q];
  assign io_out_index  = idx_mem[head_q];
  assign io_out_coreid = cid_mem[head_q];
  assign io_count      = count_q;
  assign io_overflow   = overflow_q;
  assign io_drop_cnt   = drop_cnt_q;

  always_comb begin
    deq = io_out_valid && io_out_ready;
    n = '0;
    for (int k = 0; k < NUM_CH; k++) n = n + CW'(io_in_valid[k]);
    free   = CW'(DEPTH) - count_q + CW'(deq);
    accept = !io_flush && (n <= free);
    drop   = !io_flush && (n > free);
    n_acc  = accept ? n : '0;

    // Valid channels pack densely into tail slots in channel order
    off = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_en[k]   = accept && io_in_valid[k];
      wr_addr[k] = tail_q + off[AW-1:0];
      wr_idx[k]  = seq_q + 8'(off);
      off        = off + CW'(io_in_valid[k]);
    end

    head_d  = head_q + AW'(deq);
    tail_d  = tail_q + n_acc[AW-1:0];
    count_d = count_q + n_acc - CW'(deq);
    seq_d   = seq_q + 8'(n_acc);
    if (io_flush) begin
      head_d  = head_q;
      tail_d  = head_q;
      count_d = '0;
    end

    dsum       = {1'b0, drop_cnt_q} + 17'(n);
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop) drop_cnt_d = dsum[16] ? 16'hFFFF : dsum[15:0];
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge io_clock) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_en[k]) begin
        pc_mem[wr_addr[k]]  <= io_in_pc[k*PC_W +: PC_W];
        idx_mem[wr_addr[k]] <= wr_idx[k];
        cid_mem[wr_addr[k]] <= io_coreid;
      end
    end
  end

endmodule

// File: tb/tb_difftest_runahead_commit_queue.sv
// Scoreboard bench for difftest_runahead_commit_queue (NUM_CH=2, DEPTH=8).
// Driver pushes expected head entries; a negedge monitor checks each dequeue.
module tb_difftest_runahead_commit_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   coreid;
  logic         flush;
  logic [1:0]   in_valid;
  logic [127:0] in_pc;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_coreid;
  logic [7:0]   out_index;
  logic [63:0]  out_pc;
  logic [3:0]   count;
  logic         overflow;
  logic [15:0]  drop_cnt;

  typedef struct {
    logic [7:0]  idx;
    logic [63:0] pc;
    logic [7:0]  cid;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  always #5 clk = ~clk;

  difftest_runahead_commit_queue #(
    .NUM_CH(2), .DEPTH(8), .PC_W(64)
  ) dut (
    .io_clock     (clk),
    .io_reset     (rst),
    .io_coreid    (coreid),
    .io_flush     (flush),
    .io_in_valid  (in_valid),
    .io_in_pc     (in_pc),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_coreid(out_coreid),
    .io_out_index (out_index),
    .io_out_pc    (out_pc),
    .io_count     (count),
    .io_overflow  (overflow),
    .io_drop_cnt  (drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got idx %0h expected none", out_index);
      end else begin
        e = sb.pop_front();
        chk("head_index", 64'(out_index), 64'(e.idx));
        chk("head_pc", out_pc, e.pc);
        chk("head_coreid", 64'(out_coreid), 64'(e.cid));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of events; push expectations when marked accepted
  task automatic issue(input logic [1:0] v, input logic [63:0] p0,
                       input logic [63:0] p1, input bit acc,
                       input logic [7:0] idx0);
    in_valid = v;
    in_pc    = {p1, p0};
    if (acc) begin
      if (v[0]) sb.push_back('{idx0, p0, coreid});
      if (v[1]) sb.push_back('{v[0] ? idx0 + 8'd1 : idx0, p1, coreid});
    end
    step();
    in_valid = 2'b00;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1;
    coreid = 8'h5A;
    flush = 1'b0;
    in_valid = 2'b00;
    in_pc = '0;
    out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // single event on channel 1
    out_ready = 1'b1;
    issue(2'b10, 64'h0, 64'h8000_0004, 1, 8'd0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_pc", out_pc, 64'h8000_0004);
    chk("single_index", 64'(out_index), 64'd0);
    chk("single_count", 64'(count), 64'd1);
    step();
    chk("single_count_after", 64'(count), 64'd0);

    // two channels in one cycle, held then released
    out_ready = 1'b0;
    coreid = 8'h11;
    issue(2'b11, 64'h100, 64'h104, 1, 8'd1);
    chk("order_count", 64'(count), 64'd2);
    chk("order_head_pc", out_pc, 64'h100);
    drain(2);
    chk("order_drained", 64'(count), 64'd0);

    // fill to 7, then a two-event cycle must drop whole
    out_ready = 1'b0;
    issue(2'b11, 64'h200, 64'h204, 1, 8'd3);
    issue(2'b11, 64'h208, 64'h20C, 1, 8'd5);
    issue(2'b11, 64'h210, 64'h214, 1, 8'd7);
    issue(2'b01, 64'h218, 64'h0, 1, 8'd9);
    chk("fill7_count", 64'(count), 64'd7);
    issue(2'b11, 64'hDEAD, 64'hBEEF, 0, 8'd0);
    chk("ovf_count", 64'(count), 64'd7);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    issue(2'b01, 64'h21C, 64'h0, 1, 8'd10);
    chk("full_count", 64'(count), 64'd8);

    // full with simultaneous dequeue still accepts
    out_ready = 1'b1;
    issue(2'b01, 64'h220, 64'h0, 1, 8'd11);
    chk("fulldeq_count", 64'(count), 64'd8);
    chk("fulldeq_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("fulldeq_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b0;
    issue(2'b10, 64'h0, 64'h224, 0, 8'd0);
    chk("full_drop_one", 64'(drop_cnt), 64'd3);
    drain(10);
    chk("drained_full", 64'(count), 64'd0);

    // flush discards queue and same-cycle inputs, keeps seq/sticky state
    out_ready = 1'b0;
    issue(2'b11, 64'h300, 64'h304, 0, 8'd0);
    issue(2'b11, 64'h308, 64'h30C, 0, 8'd0);
    issue(2'b01, 64'h310, 64'h0, 0, 8'd0);
    chk("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1;
    issue(2'b11, 64'h314, 64'h318, 0, 8'd0);
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("flush_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    issue(2'b01, 64'h400, 64'h0, 1, 8'd17);
    chk("post_flush_index", 64'(out_index), 64'd17);
    drain(2);

    // reset mid-stream
    out_ready = 1'b0;
    issue(2'b11, 64'h500, 64'h504, 0, 8'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_count", 64'(count), 64'd0);
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_overflow", 64'(overflow), 64'd0);
    chk("rst2_drop_cnt", 64'(drop_cnt), 64'd0);

    // 300 single events with continuous dequeue: index wraps at 256
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0)
        issue(2'b01, 64'h1000 + 64'(i), 64'h0, 1, 8'(i));
      else
        issue(2'b10, 64'h0, 64'h1000 + 64'(i), 1, 8'(i));
      if (i == 0) chk("wrap_first_index", 64'(out_index), 64'd0);
    end
    drain(4);
    chk("wrap_pops", 64'(pops), 64'd300);
    chk("wrap_count", 64'(count), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
